// File: rtl/ramsdp_fifo.sv
// ramsdp_fifo: first-word-fall-through FIFO controller wrapped around a
// simple-dual-port RAM (write port A, registered 1-cycle read port B).
// A 2-entry output buffer hides the RAM read latency so the FIFO can
// stream one word per cycle. Total capacity is 2**AW + 2 words.
//
// Handshakes: a word moves on an interface only in a cycle where its
// valid and ready are both high at the rising edge; in_ready depends only
// on registered state, and out_data holds while out_valid=1, out_ready=0.
//
// Optional feature, macro RAMSDP_FIFO_BYPASS_EN: when the RAM and the
// read pipeline are empty and the output buffer has room, a pushed word
// goes straight into the output buffer (out_valid one cycle after push).
module ramsdp_fifo #(
    parameter int DW = 16,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW+1:0] count,
    output logic          full,
    output logic          empty,
    output logic          ram_en_a,
    output logic          ram_we_a,
    output logic [AW-1:0] ram_addr_a,
    output logic [DW-1:0] ram_din_a,
    output logic          ram_en_b,
    output logic [AW-1:0] ram_addr_b,
    input  logic [DW-1:0] ram_dout_b
);

    localparam logic [AW:0] RAM_DEPTH = {1'b1, {AW{1'b0}}};

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_cnt_q, ram_cnt_d;
    logic [1:0]    ob_cnt_q, ob_cnt_d;
    logic          pend_q, pend_d;
    logic [DW-1:0] ob0_q, ob0_d;
    logic [DW-1:0] ob1_q, ob1_d;

    logic          push;
    logic          pop;
    logic          rd;
    logic          bypass;
    logic          ram_wr;
    logic          cap;
    logic [DW-1:0] cap_data;
    logic [2:0]    ob_after_pop;
    logic [2:0]    ob_load;

    // Full tracks RAM occupancy only; in_ready never looks at out_ready.
    assign full      = (ram_cnt_q == RAM_DEPTH);
    assign in_ready  = !full;
    assign push      = in_valid & in_ready;
    assign out_valid = (ob_cnt_q != 2'd0);
    assign out_data  = ob0_q;
    assign pop       = out_valid & out_ready;

    // Buffer entries left after this cycle's pop, then plus the read in flight.
    assign ob_after_pop = {1'b0, ob_cnt_q} - {2'b00, pop};
    assign ob_load      = ob_after_pop + {2'b00, pend_q};

    // A read needs a stored word and a free buffer slot when its data lands.
    // Requiring ram_cnt>=1 at cycle start keeps addr_b off the write address.
    assign rd = (ram_cnt_q != '0) && (ob_load < 3'd2);

`ifdef RAMSDP_FIFO_BYPASS_EN
    assign bypass = push && (ram_cnt_q == '0) && !pend_q && (ob_after_pop < 3'd2);
`else
    assign bypass = 1'b0;
`endif

    assign ram_wr     = push & !bypass;
    assign ram_en_a   = ram_wr;
    assign ram_we_a   = ram_wr;
    assign ram_addr_a = wr_ptr_q;
    assign ram_din_a  = in_data;
    assign ram_en_b   = rd;
    assign ram_addr_b = rd_ptr_q;

    // Returned RAM data and bypassed input never coincide (bypass needs pend=0).
    assign cap      = pend_q | bypass;
    assign cap_data = pend_q ? ram_dout_b : in_data;

    assign count = (AW+2)'(ram_cnt_q) + (AW+2)'(ob_cnt_q) + (AW+2)'(pend_q);
    assign empty = (count == '0);

    // Next-state for pointers, occupancy, read pipeline and output buffer.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        pend_d    = rd;
        ob0_d     = ob0_q;
        ob1_d     = ob1_q;
        ob_cnt_d  = ob_after_pop[1:0] + {1'b0, cap};

        if (ram_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (ram_wr && !rd) begin
            ram_cnt_d = ram_cnt_q + 1'b1;
        end else if (!ram_wr && rd) begin
            ram_cnt_d = ram_cnt_q - 1'b1;
        end

        // Pop shifts the second entry to the head; a capture lands behind
        // whatever remains, so both happen on the same edge in FIFO order.
        if (pop) begin
            ob0_d = ob1_q;
        end
        if (cap) begin
            if (ob_after_pop == 3'd0) begin
                ob0_d = cap_data;
            end else begin
                ob1_d = cap_data;
            end
        end
    end

    // State registers; reset discards any read in flight.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            ram_cnt_q <= '0;
            ob_cnt_q  <= '0;
            pend_q    <= 1'b0;
            ob0_q     <= '0;
            ob1_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            ram_cnt_q <= ram_cnt_d;
            ob_cnt_q  <= ob_cnt_d;
            pend_q    <= pend_d;
            ob0_q     <= ob0_d;
            ob1_q     <= ob1_d;
        end
    end

endmodule

// File: tb/tb_ramsdp_fifo.sv
// Testbench for ramsdp_fifo (DW=16, AW=2, capacity 6) with a behavioural
// RAM model, a queue-based reference of the FIFO contents, one per-cycle
// compare process, and directed scenarios with literal expectations.
module tb_ramsdp_fifo;

    localparam int DW    = 16;
    localparam int AW    = 2;
    localparam int DEPTH = 2 ** AW;
    localparam int CAP   = DEPTH + 2;
`ifdef RAMSDP_FIFO_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 3;
`endif

    logic          clk;
    logic          nreset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW+1:0] count;
    logic          full;
    logic          empty;
    logic          ram_en_a;
    logic          ram_we_a;
    logic [AW-1:0] ram_addr_a;
    logic [DW-1:0] ram_din_a;
    logic          ram_en_b;
    logic [AW-1:0] ram_addr_b;
    logic [DW-1:0] ram_dout_b;

    ramsdp_fifo #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .nreset     (nreset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .count      (count),
        .full       (full),
        .empty      (empty),
        .ram_en_a   (ram_en_a),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_en_b   (ram_en_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- simple-dual-port RAM model ----------------
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en_a && ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_en_b) ram_dout_b <= mem[ram_addr_b];
    end

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            stall  = 0;
    logic          hold_v = 1'b0;
    logic [DW-1:0] hold_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the queue model, then apply this cycle's transfers.
    always @(negedge clk) begin
        if (!nreset) begin
            stall  = 0;
            hold_v = 1'b0;
        end else begin
            check("count", 32'(count), 32'(exp_q.size()));
            check("empty", 32'(empty), 32'(exp_q.size() == 0));
            if (out_valid) begin
                if (exp_q.size() == 0) check("spurious_valid", 32'(out_valid), 32'd0);
                else                   check("out_data", 32'(out_data), 32'(exp_q[0]));
            end
            if (exp_q.size() < DEPTH) check("in_ready_room", 32'(in_ready), 32'd1);
            if (exp_q.size() == CAP)  check("in_ready_cap", 32'(in_ready), 32'd0);
            check("full_not_ready", 32'(full), 32'(!in_ready));
            if (ram_en_a) begin
                check("wr_is_push", 32'(in_valid && in_ready), 32'd1);
                check("wr_data", 32'(ram_din_a), 32'(in_data));
            end
            if (ram_en_a && ram_en_b) check("addr_hazard", 32'(ram_addr_a != ram_addr_b), 32'd1);
            if (hold_v) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_d));
            end
            if (exp_q.size() != 0 && !out_valid) stall++;
            else stall = 0;
            if (stall > 0) check("head_latency", 32'(stall <= 2), 32'd1);

            hold_v = out_valid && !out_ready;
            hold_d = out_data;
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && in_ready) exp_q.push_back(in_data);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) next_cycle();
        @(negedge clk);
        check("drain_empty", 32'(empty), 32'd1);
        next_cycle();
        out_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    initial begin
        bit found;
        nreset    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;

        // reset values
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_en_a", 32'(ram_en_a), 32'd0);
        check("rst_we_a", 32'(ram_we_a), 32'd0);
        check("rst_en_b", 32'(ram_en_b), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);

        // single push latency
        next_cycle();
        in_valid = 1'b1;
        in_data  = 16'h1234;
        next_cycle();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("lat_valid", 32'(out_valid), 32'(k >= LAT));
        end
        check("lat_data", 32'(out_data), 32'h1234);
        check("lat_count", 32'(count), 32'd1);
        drain();

        // fill to capacity; a seventh word is refused
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i);
            next_cycle();
        end
        in_data = 16'd7;
        @(negedge clk);
        check("fill_full", 32'(full), 32'd1);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd6);
        next_cycle();
        @(negedge clk);
        check("fill_7th_refused", 32'(count), 32'd6);
        check("fill_head", 32'(out_data), 32'd1);

        // sustained stream from full across pointer wraps
        next_cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(16'h0100 + i);
            @(negedge clk);
            check("stream_rate", 32'(out_valid), 32'd1);
            next_cycle();
        end
        drain();

        // random traffic
        for (int i = 0; i < 1000; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            next_cycle();
        end

        // reset while a RAM read is in flight
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (ram_en_b) found = 1'b1;
            next_cycle();
        end
        check("pend_seen", 32'(found), 32'd1);
        nreset    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        next_cycle();
        nreset   = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hBEEF;
        next_cycle();
        in_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
            else next_cycle();
        end
        check("post_rst_valid", 32'(found), 32'd1);
        check("post_rst_data", 32'(out_data), 32'hBEEF);
        drain();

        // head stays put while the consumer stalls and pushes continue
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 6);
            in_data  = 16'(16'hA000 + i);
            @(negedge clk);
            if (out_valid) check("stable_head", 32'(out_data), 32'hA000);
            next_cycle();
        end
        @(negedge clk);
        check("stable_count", 32'(count), 32'd6);
        next_cycle();
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramsdp_fifo.md
Name: ramsdp_fifo

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO controller that sits directly upstream of, and wraps, a simple-dual-port RAM instance.
- The RAM is a write-only port A plus a read-only port B with a registered 1-cycle read.
- This block owns the pointers, occupancy and valid/ready handshakes, and drives the RAM's port A and port B signals.
- A 2-entry output buffer hides RAM read latency, so streaming runs at 1 word/cycle.

Parameters:
- DW, 16, data width; must match the RAM DW.
- AW, 10, RAM address width; RAM depth is 2**AW; total FIFO capacity is 2**AW+2.

Ports:
- clk  in  1  single clock, rising edge
- nreset  in  1  asynchronous active-low reset
- in_valid  in  1  producer has a word
- in_ready  out  1  FIFO can accept; equals !full
- in_data  in  DW  write data
- out_valid  out  1  head word present on out_data
- out_ready  in  1  consumer takes the head word
- out_data  out  DW  head word
- count  out  AW+2  total occupancy (RAM + output buffer + in-flight read)
- full  out  1  RAM occupancy == 2**AW
- empty  out  1  count == 0
- ram_en_a  out  1  to RAM en_a
- ram_we_a  out  1  to RAM we_a
- ram_addr_a  out  AW  to RAM addr_a
- ram_din_a  out  DW  to RAM din_a
- ram_en_b  out  1  to RAM en_b
- ram_addr_b  out  AW  to RAM addr_b
- ram_dout_b  in  DW  from RAM dout_b; valid the cycle after ram_en_b

Behaviour:
- Reset: wr_ptr=0, rd_ptr=0, ram_cnt=0, ob_cnt=0, pend=0.
- Reset output values: out_valid=0, count=0, empty=1, full=0, in_ready=1, ram_en_a=0, ram_we_a=0, ram_en_b=0. out_data is 0 (buffer regs reset).
- Push:
  - push = in_valid & in_ready.
  - ram_en_a = ram_we_a = push; ram_addr_a = wr_ptr; ram_din_a = in_data (combinational).
  - wr_ptr increments modulo 2**AW (natural wrap).
- Read issue:
  - rd = (ram_cnt != 0) & (ob_cnt + pend - pop < 2), where pop = out_valid & out_ready.
  - ram_en_b = rd; ram_addr_b = rd_ptr.
  - On rd: rd_ptr increments with wrap; pend<=1, otherwise pend<=0.
- ram_cnt update: ram_cnt <= ram_cnt + push - rd. Width AW+1, never exceeds 2**AW.
- Capture: when pend==1, ram_dout_b is written into the output buffer behind any existing entries (FIFO order).
- Output buffer:
  - Holds 0..2 entries; out_valid = (ob_cnt != 0); out_data = head entry.
  - On pop the second entry shifts to head in the same edge as the capture of a new entry.
- count = ram_cnt + ob_cnt + pend, updated each edge.
- Latency, empty FIFO without bypass: push in cycle T, RAM written at edge T, rd issued cycle T+1, captured edge T+2, out_valid=1 in cycle T+3.
- Address hazard: rd only issues when ram_cnt≥1 at cycle start, so ram_addr_b never equals the address being written in the same cycle. No read-during-write ambiguity.
- Full: in_ready=0 when ram_cnt==2**AW; in_valid is ignored and the RAM is not written.
- Simultaneous push and pop when full:
  - Pop frees a buffer slot, which triggers rd the same cycle. ram_cnt drops next cycle; in_ready rises then.
  - in_ready is never combinationally dependent on out_ready.
- Empty: out_valid=0; out_ready is ignored; rd never issues.
- Handshake rules:
  - out_data is stable while out_valid=1 and out_ready=0.
  - in_valid may drop without a handshake (no hold requirement on the producer).
- Reset mid-operation: all state clears asynchronously; an in-flight RAM read is discarded (pend=0); RAM contents are don't-care.

Optional Feature:
- Macro: RAMSDP_FIFO_BYPASS_EN.
- Defined: when count==0 (or count==1 and that one entry is being popped) and push occurs, in_data is written straight into the output buffer. The RAM is not written and wr_ptr/rd_ptr are unchanged, so out_valid=1 in cycle T+1.
- Generalised rule: bypass whenever ram_cnt==0, pend==0, and ob_cnt - pop < 2.
- Not defined: all pushes go through the RAM; latency is 3 cycles as above.
- Both variants: ordering, capacity and count semantics are identical.

Test Plan (DW=16, AW=2, capacity 6):
- Reset, then one push of 0x1234 at cycle T -> out_valid=1 at T+3 with out_data=0x1234. With BYPASS_EN: at T+1. count=1.
- Push 0x0001..0x0006 back-to-back with out_ready=0 -> full=1 and in_ready=0 after 6 accepted; a 7th word offered is not accepted; count=6.
- From full, hold out_ready=1 and in_valid=1 with an incrementing stream -> output strictly ordered, 1 word/cycle sustained, no drop or duplicate across pointer wrap (≥20 words).
- Random in_valid/out_ready at 50% for 1000 cycles -> scoreboard matches; count == scoreboard depth every cycle; ram_addr_b never equals ram_addr_a when both enables are high.
- Assert nreset low mid-stream with pend=1 -> next cycle out_valid=0, count=0, empty=1. After release, push 0xBEEF -> first output is 0xBEEF.
- Hold out_ready=0 with out_valid=1 for 5 cycles while pushing -> out_data stable at the head value throughout.
